gpio_scan_ctrl: RTL and testbench
=================================

GPIO_SCAN_CTRL -- requirements
Module: gpio_scan_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_W, default 112, scan frame length in bits.
REQ-002 SHALL have port clk, input, 1, single clock for all state (driven from selected gpio_clk).
REQ-003 SHALL have port resetn, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have ports gpio_in (in, 1, serial data), gpio_scan (in, 1, shift enable), gpio_sram_load (in, 1, capture-to-chain), global_csb (in, 1, active-low access strobe), gpio_out (out, 1, serial data out).
REQ-005 SHALL have port-0 outputs sram_sel (4), csb0 (1), web0 (1), wmask0 (4), addr0 (16), din0 (32), and read input dout0 (in, 32).
REQ-006 SHALL have port-1 outputs csb1 (1), web1 (1), wmask1 (4), addr1 (16), din1 (32), and read input dout1 (in, 32).
REQ-007 SHALL have output busy (1), high in any state other than IDLE.

Function
REQ-008 Frame, MSB first: sel[3:0], addr0, din0, csb0, web0, wmask0, addr1, din1, csb1, web1, wmask1 (112 bits).
REQ-009 gpio_out SHALL be chain[CHAIN_W-1] directly from the register, no extra latency.
REQ-010 FSM states IDLE, SHIFT, ACCESS, CAPTURE, LOAD; next state decoded from inputs sampled each clk edge.
REQ-011 Priority: gpio_scan=1 -> SHIFT; else gpio_sram_load=1 -> LOAD; else global_csb=0 -> ACCESS; else IDLE, except ACCESS always proceeds to CAPTURE for exactly one cycle.
REQ-012 SHIFT: chain <= {chain[CHAIN_W-2:0], gpio_in} each cycle with gpio_scan=1.
REQ-013 Port outputs other than csb SHALL equal their chain fields continuously.
REQ-014 csb0 = chain.csb0 OR global_csb OR gpio_scan OR gpio_sram_load; csb1 likewise; scan or load simultaneous with global_csb=0 SHALL suppress the access.
REQ-015 CAPTURE (cycle after an ACCESS cycle): dout0/dout1 registered into capture FFs on the closing edge; ports with chain csb=1 leave their capture FF unchanged.
REQ-016 LOAD: din0 field <= capture0, din1 field <= capture1; all other fields unchanged; one cycle.
REQ-017 global_csb held low N cycles SHALL yield N accesses, each followed by CAPTURE semantics (capture every cycle after an access cycle).
REQ-018 gpio_scan asserted during CAPTURE: capture still completes on that edge; shift also occurs.

Reset
REQ-019 On resetn=0: chain all zeros except csb0/csb1 bits =1, capture FFs 0, state IDLE, busy 0, gpio_out 0, csb0=csb1=1.
REQ-020 Reset mid-SHIFT or mid-ACCESS SHALL abort immediately; no partial capture survives.

Configuration
REQ-021 Macro SCAN_LOOPBACK_EN: when defined, sram_sel=4'hF routes a 32-bit internal echo register (written on ACCESS with web0=0, csb0=0 from din0) to both capture FFs instead of dout0/dout1; when undefined, sel=4'hF behaves like any other sel (external dout used), and no echo register exists.

Structure
REQ-022 Shared package holds CHAIN_W default, field bit-offset constants, and FSM state enum.
REQ-023 No sub-modules; single flat module; SRAM dout muxing by sram_sel lives outside this block.

Verification
REQ-024 Reset then 112 shifts of 0xA5-pattern, then 112 more shifts of zeros -> gpio_out reproduces pattern MSB first, delayed exactly 112 cycles.
REQ-025 Shift frame sel=2, addr0=1, din0=0x2, csb0=0, web0=0, csb1=1; global_csb low 1 cycle -> csb0 low exactly 1 cycle with addr0=1, din0=2, web0=0; csb1 stays 1.
REQ-026 Read frame csb0=0, web0=1, addr0=1, csb1=0, addr1=2, model dout0=0x2, dout1=0x10; global_csb low 1, high 1, sram_load 1, then scan -> scanned-out din0=0x2, din1=0x10, other fields as shifted in.
REQ-027 global_csb=0 together with gpio_scan=1 -> csb0/csb1 remain 1, chain shifts, no capture.
REQ-028 resetn pulsed low mid-shift at bit 50 -> chain reset value, busy 0, csb0=csb1=1 immediately.
REQ-029 With SCAN_LOOPBACK_EN, sel=4'hF write 0xDEADBEEF then read/load/scan -> din0 field 0xDEADBEEF with dout inputs driven X.

Source files
------------

// File: rtl/gpio_scan_ctrl_pkg.sv
// rtl/gpio_scan_ctrl_pkg.sv - frame geometry and FSM state type for gpio_scan_ctrl
package gpio_scan_ctrl_pkg;

   localparam int CHAIN_W_DEF = 112;

   // Field LSB positions; the frame is shifted MSB first, sel at the top
   localparam int OFF_WMASK1  = 0;
   localparam int OFF_WEB1    = 4;
   localparam int OFF_CSB1    = 5;
   localparam int OFF_DIN1    = 6;
   localparam int OFF_ADDR1   = 38;
   localparam int OFF_WMASK0  = 54;
   localparam int OFF_WEB0    = 58;
   localparam int OFF_CSB0    = 59;
   localparam int OFF_DIN0    = 60;
   localparam int OFF_ADDR0   = 92;
   localparam int OFF_SEL     = 108;

   localparam logic [3:0] SEL_LOOPBACK = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_ACCESS,
      ST_CAPTURE,
      ST_LOAD
   } state_t;

endpackage

// File: rtl/gpio_scan_ctrl.sv
// rtl/gpio_scan_ctrl.sv - GPIO scan chain driving two SRAM ports, with read-back capture
// Optional macro SCAN_LOOPBACK_EN: sram_sel=4'hF reads an internal echo register instead of dout.
module gpio_scan_ctrl
   import gpio_scan_ctrl_pkg::*;
#(
   parameter int CHAIN_W = CHAIN_W_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        gpio_in,
   input  logic        gpio_scan,
   input  logic        gpio_sram_load,
   input  logic        global_csb,
   output logic        gpio_out,
   output logic [3:0]  sram_sel,
   output logic        csb0,
   output logic        web0,
   output logic [3:0]  wmask0,
   output logic [15:0] addr0,
   output logic [31:0] din0,
   input  logic [31:0] dout0,
   output logic        csb1,
   output logic        web1,
   output logic [3:0]  wmask1,
   output logic [15:0] addr1,
   output logic [31:0] din1,
   input  logic [31:0] dout1,
   output logic        busy
);

   localparam logic [CHAIN_W-1:0] CHAIN_RST =
      (CHAIN_W'(1) << OFF_CSB0) | (CHAIN_W'(1) << OFF_CSB1);

   logic [CHAIN_W-1:0] r_chain;
   logic [31:0]        r_cap0;
   logic [31:0]        r_cap1;
   logic               r_acc0;
   logic               r_acc1;
   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_csb0;
   logic               w_csb1;
   logic [31:0]        w_src0;
   logic [31:0]        w_src1;

   assign gpio_out = r_chain[CHAIN_W-1];
   assign sram_sel = r_chain[OFF_SEL +: 4];
   assign addr0    = r_chain[OFF_ADDR0 +: 16];
   assign din0     = r_chain[OFF_DIN0 +: 32];
   assign web0     = r_chain[OFF_WEB0];
   assign wmask0   = r_chain[OFF_WMASK0 +: 4];
   assign addr1    = r_chain[OFF_ADDR1 +: 16];
   assign din1     = r_chain[OFF_DIN1 +: 32];
   assign web1     = r_chain[OFF_WEB1];
   assign wmask1   = r_chain[OFF_WMASK1 +: 4];

   // Scan or load in the same cycle as the strobe kills the access outright
   assign w_csb0 = r_chain[OFF_CSB0] | global_csb | gpio_scan | gpio_sram_load;
   assign w_csb1 = r_chain[OFF_CSB1] | global_csb | gpio_scan | gpio_sram_load;
   assign csb0   = w_csb0;
   assign csb1   = w_csb1;
   assign busy   = (r_state != ST_IDLE);

   always_comb begin
      w_state_nxt = ST_IDLE;
      if (r_state == ST_ACCESS) begin
         w_state_nxt = ST_CAPTURE;
      end else if (gpio_scan) begin
         w_state_nxt = ST_SHIFT;
      end else if (gpio_sram_load) begin
         w_state_nxt = ST_LOAD;
      end else if (!global_csb) begin
         w_state_nxt = ST_ACCESS;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

`ifdef SCAN_LOOPBACK_EN
   logic [31:0] r_echo;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_echo <= '0;
      end else if (!w_csb0 && !web0 && (sram_sel == SEL_LOOPBACK)) begin
         r_echo <= din0;
      end
   end

   assign w_src0 = (sram_sel == SEL_LOOPBACK) ? r_echo : dout0;
   assign w_src1 = (sram_sel == SEL_LOOPBACK) ? r_echo : dout1;
`else
   assign w_src0 = dout0;
   assign w_src1 = dout1;
`endif

   // SRAM read data is valid the cycle after the access, so the access flag is pipelined
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_acc0 <= 1'b0;
         r_acc1 <= 1'b0;
         r_cap0 <= '0;
         r_cap1 <= '0;
      end else begin
         r_acc0 <= ~w_csb0;
         r_acc1 <= ~w_csb1;
         if (r_acc0) begin
            r_cap0 <= w_src0;
         end
         if (r_acc1) begin
            r_cap1 <= w_src1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_chain <= CHAIN_RST;
      end else if (gpio_scan) begin
         r_chain <= {r_chain[CHAIN_W-2:0], gpio_in};
      end else if (gpio_sram_load) begin
         r_chain[OFF_DIN0 +: 32] <= r_cap0;
         r_chain[OFF_DIN1 +: 32] <= r_cap1;
      end
   end

endmodule

// File: tb/tb_gpio_scan_ctrl.sv
// tb/tb_gpio_scan_ctrl.sv - directed table-driven bench for gpio_scan_ctrl
module tb_gpio_scan_ctrl;

   logic        clk;
   logic        resetn;
   logic        gpio_in;
   logic        gpio_scan;
   logic        gpio_sram_load;
   logic        global_csb;
   logic        gpio_out;
   logic [3:0]  sram_sel;
   logic        csb0;
   logic        web0;
   logic [3:0]  wmask0;
   logic [15:0] addr0;
   logic [31:0] din0;
   logic [31:0] dout0;
   logic        csb1;
   logic        web1;
   logic [3:0]  wmask1;
   logic [15:0] addr1;
   logic [31:0] din1;
   logic [31:0] dout1;
   logic        busy;

   int n_vec;
   int n_err;

   gpio_scan_ctrl #(.CHAIN_W(112)) dut (
      .clk(clk), .resetn(resetn), .gpio_in(gpio_in), .gpio_scan(gpio_scan),
      .gpio_sram_load(gpio_sram_load), .global_csb(global_csb), .gpio_out(gpio_out),
      .sram_sel(sram_sel), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
      .din0(din0), .dout0(dout0), .csb1(csb1), .web1(web1), .wmask1(wmask1),
      .addr1(addr1), .din1(din1), .dout1(dout1), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  sel;
      logic [15:0] a0;
      logic [31:0] wd0;
      logic        c0;
      logic        w0;
      logic [3:0]  m0;
      logic [15:0] a1;
      logic [31:0] wd1;
      logic        c1;
      logic        w1;
      logic [3:0]  m1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   vec_t tbl [5];

   function automatic logic [111:0] mk_frame(
      input logic [3:0] sel, input logic [15:0] a0, input logic [31:0] d0,
      input logic c0, input logic w0, input logic [3:0] m0,
      input logic [15:0] a1, input logic [31:0] d1,
      input logic c1, input logic w1, input logic [3:0] m1);
      return {sel, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
   endfunction

   function automatic logic [111:0] set_din(input logic [111:0] f,
                                            input logic [31:0] d0, input logic [31:0] d1);
      logic [111:0] r;
      r = f;
      r[91:60] = d0;
      r[37:6]  = d1;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [111:0] got, input logic [111:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic shift_frame(input logic [111:0] f);
      for (int i = 111; i >= 0; i--) begin
         gpio_scan = 1'b1;
         gpio_in   = f[i];
         step();
      end
      gpio_scan = 1'b0;
      gpio_in   = 1'b0;
   endtask

   task automatic scan_out(output logic [111:0] got);
      for (int i = 111; i >= 0; i--) begin
         gpio_scan = 1'b1;
         gpio_in   = 1'b0;
         #1 got[i] = gpio_out;
         step();
      end
      gpio_scan = 1'b0;
   endtask

   task automatic load_cycle();
      gpio_sram_load = 1'b1;
      step();
      gpio_sram_load = 1'b0;
   endtask

   logic [111:0] got;
   logic [111:0] frm;
   logic [111:0] pat;
   logic [111:0] rst_frame;

   initial begin
      n_vec = 0;
      n_err = 0;
      resetn = 1'b0;
      gpio_in = 1'b0;
      gpio_scan = 1'b0;
      gpio_sram_load = 1'b0;
      global_csb = 1'b1;
      dout0 = '0;
      dout1 = '0;
      rst_frame = mk_frame(4'h0, 16'h0, 32'h0, 1'b1, 1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 1'b0, 4'h0);

      tbl[0] = '{4'h0, 16'h0001, 32'h11111111, 1'b0, 1'b1, 4'hF, 16'h0002, 32'h22222222, 1'b0, 1'b1, 4'hF,
                 32'h00000002, 32'h00000010, 32'h00000002, 32'h00000010};
      tbl[1] = '{4'h1, 16'h00AB, 32'h33333333, 1'b0, 1'b1, 4'h3, 16'h00CD, 32'h44444444, 1'b1, 1'b1, 4'h0,
                 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D, 32'h00000010};
      tbl[2] = '{4'h7, 16'hFFFF, 32'h00000000, 1'b1, 1'b1, 4'h0, 16'h8001, 32'hFFFFFFFF, 1'b0, 1'b1, 4'hC,
                 32'hFFFFFFFF, 32'hA5A5A5A5, 32'hCAFEF00D, 32'hA5A5A5A5};
      tbl[3] = '{4'h8, 16'h1234, 32'h5A5A5A5A, 1'b1, 1'b0, 4'hF, 16'h4321, 32'hA5A5A5A5, 1'b1, 1'b0, 4'hF,
                 32'h99999999, 32'h00000000, 32'hCAFEF00D, 32'hA5A5A5A5};
      tbl[4] = '{4'h2, 16'h0001, 32'h00000002, 1'b0, 1'b0, 4'hF, 16'h0000, 32'h00000000, 1'b1, 1'b1, 4'h0,
                 32'h0BADBEEF, 32'h00000077, 32'h0BADBEEF, 32'hA5A5A5A5};

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_gpio_out", gpio_out, 1'b0);
      chk("rst_csb", {csb0, csb1}, 2'b11);
      chk("rst_fields", {sram_sel, addr0, din0, web0, wmask0, addr1, din1, web1, wmask1}, '0);
      resetn = 1'b1;
      step();

      // 0xA5 pattern reappears on gpio_out exactly one frame later
      pat = {14{8'hA5}};
      shift_frame(pat);
      chk("shift_busy", busy, 1'b1);
      scan_out(got);
      chk("pattern_delay", got, pat);
      step();
      chk("idle_busy", busy, 1'b0);

      for (int k = 0; k < 5; k++) begin
         frm = mk_frame(tbl[k].sel, tbl[k].a0, tbl[k].wd0, tbl[k].c0, tbl[k].w0, tbl[k].m0,
                        tbl[k].a1, tbl[k].wd1, tbl[k].c1, tbl[k].w1, tbl[k].m1);
         shift_frame(frm);
         global_csb = 1'b0;
         #1;
         chk($sformatf("v%0d_csb0", k), csb0, tbl[k].c0);
         chk($sformatf("v%0d_csb1", k), csb1, tbl[k].c1);
         chk($sformatf("v%0d_fields", k),
             {sram_sel, addr0, din0, web0, wmask0, addr1, din1, web1, wmask1},
             {tbl[k].sel, tbl[k].a0, tbl[k].wd0, tbl[k].w0, tbl[k].m0,
              tbl[k].a1, tbl[k].wd1, tbl[k].w1, tbl[k].m1});
         step();
         global_csb = 1'b1;
         dout0 = tbl[k].d0;
         dout1 = tbl[k].d1;
         #1;
         chk($sformatf("v%0d_csb0_one_cycle", k), csb0, 1'b1);
         step();
         dout0 = 32'h0;
         dout1 = 32'h0;
         load_cycle();
         scan_out(got);
         chk($sformatf("v%0d_scan_back", k), got,
             mk_frame(tbl[k].sel, tbl[k].a0, tbl[k].e0, tbl[k].c0, tbl[k].w0, tbl[k].m0,
                      tbl[k].a1, tbl[k].e1, tbl[k].c1, tbl[k].w1, tbl[k].m1));
      end

      // strobe together with scan: no access, chain shifts, captures hold
      frm = mk_frame(4'h3, 16'h0003, 32'h0, 1'b0, 1'b1, 4'hF, 16'h0004, 32'h0, 1'b0, 1'b1, 4'hF);
      shift_frame(frm);
      global_csb = 1'b0;
      gpio_scan = 1'b1;
      gpio_in = 1'b1;
      #1;
      chk("scan_suppress_csb", {csb0, csb1}, 2'b11);
      step();
      gpio_scan = 1'b0;
      gpio_in = 1'b0;
      global_csb = 1'b1;
      dout0 = 32'hDEAD0000;
      dout1 = 32'hDEAD0001;
      step();
      dout0 = 32'h0;
      dout1 = 32'h0;
      load_cycle();
      scan_out(got);
      chk("scan_suppress_frame", got, set_din({frm[110:0], 1'b1}, 32'h0BADBEEF, 32'hA5A5A5A5));

      // back-to-back accesses, last capture coincident with a shift
      frm = mk_frame(4'h1, 16'h0010, 32'h0, 1'b0, 1'b1, 4'hF, 16'h0020, 32'h0, 1'b1, 1'b1, 4'h0);
      shift_frame(frm);
      global_csb = 1'b0;
      #1;
      chk("burst_csb0_a", csb0, 1'b0);
      step();
      dout0 = 32'h1111AAAA;
      #1;
      chk("burst_csb0_b", csb0, 1'b0);
      chk("burst_busy", busy, 1'b1);
      step();
      global_csb = 1'b1;
      gpio_scan = 1'b1;
      gpio_in = 1'b0;
      dout0 = 32'h2222BBBB;
      #1;
      chk("burst_csb0_end", csb0, 1'b1);
      step();
      gpio_scan = 1'b0;
      dout0 = 32'h0;
      load_cycle();
      scan_out(got);
      chk("burst_capture_shift", got, set_din({frm[110:0], 1'b0}, 32'h2222BBBB, 32'hA5A5A5A5));

      // asynchronous reset 50 bits into a shift
      for (int i = 0; i < 50; i++) begin
         gpio_scan = 1'b1;
         gpio_in = 1'b1;
         step();
      end
      gpio_scan = 1'b0;
      global_csb = 1'b0;
      #2 resetn = 1'b0;
      #1;
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_csb", {csb0, csb1}, 2'b11);
      chk("rst_mid_gpio_out", gpio_out, 1'b0);
      step();
      global_csb = 1'b1;
      resetn = 1'b1;
      step();
      scan_out(got);
      chk("rst_mid_frame", got, rst_frame);

      // reset during the capture cycle leaves nothing behind
      frm = mk_frame(4'h0, 16'h0005, 32'h0, 1'b0, 1'b1, 4'hF, 16'h0006, 32'h0, 1'b0, 1'b1, 4'hF);
      shift_frame(frm);
      global_csb = 1'b0;
      step();
      global_csb = 1'b1;
      dout0 = 32'h55555555;
      dout1 = 32'h66666666;
      #2 resetn = 1'b0;
      step();
      resetn = 1'b1;
      step();
      dout0 = 32'h0;
      dout1 = 32'h0;
      load_cycle();
      scan_out(got);
      chk("rst_access_frame", got, rst_frame);

      // sel=4'hF: echo register with the macro, ordinary external read without it
      frm = mk_frame(4'hF, 16'h0001, 32'hDEADBEEF, 1'b0, 1'b0, 4'hF, 16'h0, 32'h0, 1'b1, 1'b1, 4'h0);
      shift_frame(frm);
      global_csb = 1'b0;
      step();
      global_csb = 1'b1;
      step();
      frm = mk_frame(4'hF, 16'h0001, 32'h0, 1'b0, 1'b1, 4'hF, 16'h0, 32'h0, 1'b0, 1'b1, 4'hF);
      shift_frame(frm);
      global_csb = 1'b0;
      step();
      global_csb = 1'b1;
`ifdef SCAN_LOOPBACK_EN
      dout0 = 'x;
      dout1 = 'x;
`else
      dout0 = 32'h13572468;
      dout1 = 32'h24681357;
`endif
      step();
      dout0 = 32'h0;
      dout1 = 32'h0;
      load_cycle();
      scan_out(got);
`ifdef SCAN_LOOPBACK_EN
      chk("sel_f_read", got, set_din(frm, 32'hDEADBEEF, 32'hDEADBEEF));
`else
      chk("sel_f_read", got, set_din(frm, 32'h13572468, 32'h24681357));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
